fetch_queue_unit: RTL and testbench

Decoupled instruction-fetch front end for the next-generation LEGv8 core. Owns the program counter, issues sequential word requests to a synchronous instruction memory with a one-cycle read latency, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. Decode consumes the FIFO through a valid/ready handshake. A redirect from branch resolution flushes the FIFO and discards any in-flight fetch.

---
 rtl/fetch_queue_unit.sv | 86 ++++++++
 tb/tb_fetch_queue_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: PC, one-deep in-flight tracking and a DEPTH-entry fetch FIFO.
// Optional combinational bypass of an empty FIFO is enabled with `define FETCH_QUEUE_BYPASS_EN.
module fetch_queue_unit #(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fetch_en,
  output logic                         imem_req,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]           imem_data,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         out_valid,
  output logic [INSTR_W-1:0]           out_instr,
  output logic [ADDR_W-1:0]            out_pc,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [ADDR_W-1:0] fetch_pc, inflight_pc;
  logic              inflight;
  logic              fifo_valid, enq, deq;
  logic [CW:0]       credits;

  // Credits count the in-flight slot; a same-cycle dequeue is deliberately not credited.
  assign credits    = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign imem_req   = fetch_en & ~reset & ~redirect & (credits < (CW+1)'(DEPTH));
  assign imem_addr  = fetch_pc;
  assign fifo_valid = (count != '0);
  assign deq        = fifo_valid & out_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp;
  assign byp       = ~fifo_valid & inflight & ~redirect & ~reset;
  assign out_valid = fifo_valid | byp;
  assign out_instr = byp ? imem_data   : mem[rd_ptr].instr;
  assign out_pc    = byp ? inflight_pc : mem[rd_ptr].pc;
  // A response consumed straight off the bypass never lands in the FIFO.
  assign enq       = inflight & ~(byp & out_ready);
`else
  assign out_valid = fifo_valid;
  assign out_instr = mem[rd_ptr].instr;
  assign out_pc    = mem[rd_ptr].pc;
  assign enq       = inflight;
`endif

  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      fetch_pc <= reset ? RESET_PC : {redirect_pc[ADDR_W-1:2], 2'b00};
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq && !reset && !redirect) mem[wr_ptr] <= '{pc: inflight_pc, instr: imem_data};
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed + randomized bench for fetch_queue_unit against a queue-based reference model.
module tb_fetch_queue_unit;
  localparam int AW = 64, IW = 32, D = 4;

  logic          clk = 1'b0;
  logic          reset, fetch_en, imem_req, redirect, out_valid, out_ready;
  logic [AW-1:0] imem_addr, redirect_pc, out_pc;
  logic [IW-1:0] imem_data, out_instr;
  logic [2:0]    count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_queue_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(D), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_data(imem_data), .redirect(redirect),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_ready(out_ready), .count(count)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  bit          m_inf = 0;
  bit          init  = 0;
  logic [63:0] m_pc  = '0;
  logic [63:0] m_ipc = '0;

  logic        s_req, s_valid;
  logic [63:0] s_addr, s_pc;
  logic [31:0] s_instr;
  logic [2:0]  s_count;

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] memf(logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h1357_0000;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, sample/check, advance model, move to next negedge.
  task automatic step(bit rst, bit fe, bit rdy, bit rd, logic [63:0] rpc);
    bit          e_req, e_valid, byp;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
    reset = rst; fetch_en = fe; out_ready = rdy; redirect = rd; redirect_pc = rpc;
    imem_data = m_inf ? memf(m_ipc) : $urandom;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = out_valid;
    s_pc = out_pc; s_instr = out_instr; s_count = count;
    byp = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = m_inf && q.size() == 0 && !rd && !rst;
`endif
    e_req   = fe && !rst && !rd && (q.size() + int'(m_inf) < D);
    e_valid = q.size() > 0 || byp;
    e_pc = '0; e_instr = '0;
    if (byp) begin
      e_pc = m_ipc; e_instr = memf(m_ipc);
    end else if (q.size() > 0) begin
      e_pc = q[0].pc; e_instr = q[0].instr;
    end
    if (init) begin
      chk("imem_req", s_req, e_req);
      chk("imem_addr", s_addr, m_pc);
      chk("out_valid", s_valid, e_valid);
      chk("count", s_count, q.size());
      if (e_valid) begin
        chk("out_pc", s_pc, e_pc);
        chk("out_instr", s_instr, e_instr);
      end
    end
    if (rst) begin
      q.delete(); m_inf = 0; m_pc = '0; init = 1;
    end else if (rd) begin
      q.delete(); m_inf = 0; m_pc = {rpc[63:2], 2'b00};
    end else begin
      if (!(byp && rdy)) begin
        if (q.size() > 0 && rdy) void'(q.pop_front());
        if (m_inf) q.push_back('{m_ipc, memf(m_ipc)});
      end
      if (e_req) begin
        m_ipc = m_pc; m_pc = m_pc + 64'd4;
      end
      m_inf = e_req;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int nreq;
    logic [63:0] rpc;
    reset = 1; fetch_en = 0; out_ready = 0; redirect = 0; redirect_pc = '0; imem_data = '0;
    @(negedge clk);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_count", s_count, 0);
    chk("rst_valid", s_valid, 0);
    chk("rst_addr", s_addr, 0);

    // Streaming with out_ready held high
    step(0, 1, 1, 0, 0); chk("s_addr_c1", s_addr, 0); chk("s_req_c1", s_req, 1);
    step(0, 1, 1, 0, 0); chk("s_addr_c2", s_addr, 4);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_valid_c2", s_valid, 1); chk("byp_pc_c2", s_pc, 0);
    chk("byp_instr_c2", s_instr, memf(0)); chk("byp_count_c2", s_count, 0);
`endif
    step(0, 1, 1, 0, 0); chk("s_addr_c3", s_addr, 8);
`ifndef FETCH_QUEUE_BYPASS_EN
    chk("s_valid_c3", s_valid, 1); chk("s_pc_c3", s_pc, 0);
`endif
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);

    // Fill with out_ready low, then drain
    step(1, 1, 0, 0, 0);
    nreq = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0, 0);
      if (s_req) nreq++;
    end
    chk("fill_nreq", nreq, 4);
    chk("fill_count", s_count, 4);
    chk("fill_req", s_req, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 0, 0);
      chk("drain_pc", s_pc, 64'(i * 4));
    end
    step(0, 1, 1, 0, 0); chk("drain_resume", s_req, 1);

    // Redirect with three entries queued and one in flight
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 64'h103);
    chk("rd_pre_count", s_count, 3);
    step(0, 1, 1, 0, 0);
    chk("rd_count", s_count, 0); chk("rd_valid0", s_valid, 0);
    chk("rd_req", s_req, 1); chk("rd_addr", s_addr, 64'h100);
    for (int i = 0; i < 4 && !s_valid; i++) step(0, 1, 1, 0, 0);
    chk("rd_valid", s_valid, 1); chk("rd_pc", s_pc, 64'h100);

    // Address wrap through the top of the address space
    step(0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8);
    step(0, 1, 1, 0, 0); chk("wrap_a0", s_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    step(0, 1, 1, 0, 0); chk("wrap_a1", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 1, 1, 0, 0); chk("wrap_a2", s_addr, 64'h0);
    step(0, 1, 1, 0, 0); chk("wrap_a3", s_addr, 64'h4);
    for (int i = 0; i < 12; i++) step(0, 1, (i % 3) != 0, 0, 0);

    // Fill, stream at full, then reset mid-stream
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("mrst_count", s_count, 0); chk("mrst_valid", s_valid, 0);
    chk("mrst_addr", s_addr, 0); chk("mrst_req", s_req, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rpc = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8,
           $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
